imem_loader: RTL

- Writer side of the instruction path: streams a program from a byte source (UART receiver) into the single-cycle core's instruction memory.
- Assembles big-endian bytes into 32-bit MIPS words and writes them to consecutive imem addresses.
- Holds the core in reset until the load is complete, so the control decoder only ever sees loaded opcodes.
- Sits between the board UART RX and imem/top-level reset.

---
 rtl/mips_pkg.sv | 35 +++
 rtl/word_assembler.sv | 29 ++
 rtl/imem_loader.sv | 113 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS opcode constants and instruction-loader state encoding.
// op_supported() lists the opcodes the single-cycle decoder implements.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    BYTES,
    WRITE,
    DONE,
    ERR
  } load_state_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI,
      OP_J, OP_BNE, OP_ORI, OP_ANDI, OP_SLTI:
        op_supported = 1'b1;
      default:
        op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs four big-endian bytes into a 32-bit word.
// word_ready pulses combinationally with the 4th byte.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= 2'd0;
      word <= 32'd0;
    end else if (clear) begin
      cnt <= 2'd0;
    end else if (byte_valid) begin
      word <= {word[23:0], byte_data};
      cnt  <= cnt + 2'd1;
    end
  end

  assign word_ready = byte_valid && (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-serial program into imem, holding the core in reset.
// Define IMEM_LOADER_OPCHECK_EN to reject words with unsupported opcodes.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [8:0] DEPTH = 9'(2 ** ADDR_W);

  load_state_t       state, state_n;
  logic [ADDR_W:0]   n;
  logic [ADDR_W-1:0] addr;
  logic              take, feed, word_ready;
  logic              ld_count, do_write, last, bad_n;

  assign take  = rx_valid && rx_ready;
  assign feed  = take && (state == BYTES);
  assign last  = (words_loaded + 1'b1) == n;
  assign bad_n = (rx_data == 8'd0) || ({1'b0, rx_data} > DEPTH);

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (state == COUNT),
    .byte_valid(feed),
    .byte_data (rx_data),
    .word      (imem_wd),
    .word_ready(word_ready)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      n            <= '0;
      addr         <= '0;
      words_loaded <= '0;
    end else begin
      state <= state_n;
      if (ld_count) begin
        n            <= (ADDR_W+1)'(rx_data);
        addr         <= '0;
        words_loaded <= '0;
      end
      if (do_write) begin
        words_loaded <= words_loaded + 1'b1;
        // hold at the final address so a full-depth load never wraps
        if (!last)
          addr <= addr + 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    ld_count = 1'b0;
    do_write = 1'b0;
    case (state)
      IDLE:
        if (start) state_n = COUNT;
      COUNT:
        if (take) begin
          if (bad_n) begin
            state_n = ERR;
          end else begin
            ld_count = 1'b1;
            state_n  = BYTES;
          end
        end
      BYTES:
        if (word_ready) state_n = WRITE;
      WRITE: begin
`ifdef IMEM_LOADER_OPCHECK_EN
        if (!op_supported(imem_wd[31:26])) begin
          state_n = ERR;
        end else begin
          do_write = 1'b1;
          state_n  = last ? DONE : BYTES;
        end
`else
        do_write = 1'b1;
        state_n  = last ? DONE : BYTES;
`endif
      end
      DONE, ERR:
        if (start) state_n = COUNT;
      default:
        state_n = IDLE;
    endcase
  end

  assign rx_ready  = (state == COUNT) || (state == BYTES);
  assign imem_we   = do_write;
  assign imem_addr = addr;
  assign done      = (state == DONE) && !start;
  assign error     = (state == ERR) && !start;
  assign cpu_hold  = !done;

endmodule
